minesweeper_board: RTL and testbench
====================================

Name: minesweeper_board

Overview:
- 5x5 Minesweeper game-state engine with a fixed mine layout, registered reveal state and precomputed neighbour counts.
- Accepts "flip cell N" requests from the UI/controller, runs a flood-fill cascade for zero-count cells, and tracks lose and win conditions.
- Provides a combinational pixel-to-cell lookup so the VGA renderer can draw the board at a movable top-left origin.

Parameters:
- CELL_SIZE, 32: cell edge in pixels; must be a power of two.
- MINE_MASK, 25'h0010102: bit i=1 means cell i holds a mine. Default mines are at cells 1, 8 and 16.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flip  in  1  level request to flip a cell; a rising edge triggers the flip.
- VGAid  in  32  index of the cell to flip, as row*5+col, valid 0..24.
- x_topleft  in  10  pixel x of the board's top-left corner.
- y_topleft  in  9  pixel y of the board's top-left corner.
- pix_x  in  10  current VGA pixel x.
- pix_y  in  9  current VGA pixel y.
- in_board  out  1  current pixel lies inside the board.
- pix_cell  out  5  cell index under the current pixel; 0 when outside the board.
- pix_revealed  out  1  cell under the pixel is revealed.
- pix_mine  out  1  cell under the pixel is a mine.
- pix_count  out  4  neighbour-mine count of the cell under the pixel (0..8).
- game_over  out  1  a mine has been flipped.
- game_won  out  1  all non-mine cells are revealed.
- busy  out  1  cascade in progress.
- revealed_count  out  5  number of revealed cells.

Behaviour:
- State registers:
  - revealed[24:0].
  - count[i] (4 bits, one per cell).
  - flip_q, game_over, busy.
- Cell i sits at row i/5, col i%5.
- count[i] = number of mines among the up-to-8 in-grid neighbours of i; edges and corners have no wrap-around.
- count[i] is derived combinationally from MINE_MASK and loaded on reset; it is constant afterwards.
- Reset (reset=0, asynchronous):
  - revealed=0, game_over=0, busy=0, flip_q=0.
  - game_won=0, revealed_count=0.
- Flip event: flip=1 and flip_q=0 on the same clock edge. flip_q <= flip every cycle.
  - Holding flip high produces only one event.
  - VGAid is sampled on the event cycle.
- An event is ignored if any of these holds:
  - VGAid > 24 (all 32 bits are compared),
  - game_over or game_won is 1,
  - busy is 1,
  - revealed[VGAid] is already 1.
- Accepted event on a mine cell:
  - next edge: revealed[VGAid]=1, game_over=1, and every mine cell is revealed.
- Accepted event on a non-mine cell:
  - next edge: revealed[VGAid]=1.
  - If its count is 0, busy=1 on the same edge.
- Cascade, while busy, one sweep per cycle:
  - Every unrevealed non-mine cell adjacent to a revealed count-0 cell becomes revealed.
  - When a sweep reveals nothing, busy drops to 0 on that edge.
  - Maximum cascade length is 25 cycles.
- game_won = (revealed_count == 25 − popcount(MINE_MASK)) && !game_over, registered. Once game_won is set, further flips are ignored.
- revealed_count = popcount(revealed), registered.
- Pixel lookup (purely combinational):
  - in_board = pix_x in [x_topleft, x_topleft+5*CELL_SIZE) and pix_y in [y_topleft, y_topleft+5*CELL_SIZE).
  - Comparisons use widths extended by 3 bits, so the origin-plus-board sum cannot overflow.
  - col = (pix_x−x_topleft)/CELL_SIZE and row = (pix_y−y_topleft)/CELL_SIZE, implemented as shifts.
  - pix_cell = row*5+col.
  - pix_revealed, pix_mine and pix_count index the registered state at pix_cell.
  - Outside the board all pix_* outputs are 0.
- Simultaneous events:
  - A reset assertion mid-cascade clears all state immediately.
  - A flip edge during busy is lost, not queued.

Test Plan:
- Reset check: hold reset=0, then release to 1. Require:
  - revealed_count=0, game_over=0, busy=0.
  - count[2]=2, count[9]=1, count[20]=1, count[24]=0, count[12]=2.
- Simple flips: VGAid=9 pulse for 10 cycles, then 2, then 20. Require:
  - only cells 9, 2 and 20 revealed, one each;
  - revealed_count=3;
  - busy never asserted.
- Mine hit and lockout: after the previous scenario, pulse VGAid=1. Then pulse VGAid=15. Require:
  - game_over=1 one cycle after the VGAid=1 edge;
  - cells 1, 8 and 16 revealed;
  - revealed_count=6;
  - the VGAid=15 flip is ignored and revealed[15] stays 0.
- Cascade: from reset, flip VGAid=24. Require:
  - busy high for 3 cycles;
  - final revealed set = {12,13,14,17,18,19,22,23,24};
  - revealed_count=9.
- Edge cases: flip VGAid=30, re-flip an already revealed cell, and keep flip held high for 100 cycles. Require:
  - no state change on the invalid or repeated flips;
  - the held flip produces a single event.
- Pixel lookup: x_topleft=5, y_topleft=3, pix=(5+32*2+1, 3+32*1), with cell 7 revealed. Require:
  - in_board=1, pix_cell=7, pix_revealed=1, pix_count=2.
  - pix_x=4 (left of the board) gives in_board=0.

Source files
------------

// File: rtl/minesweeper_board.sv
// minesweeper_board
//   5x5 Minesweeper game-state engine. Mines sit at fixed positions given by
//   MINE_MASK. The per-cell neighbour-mine counts are loaded on reset and
//   held. A rising edge on flip reveals the cell addressed by VGAid. Flipping
//   a zero-count cell starts a flood-fill cascade that runs one sweep per
//   cycle. Flipping a mine ends the game and reveals every mine. A
//   combinational pixel-to-cell lookup feeds the VGA renderer.
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   asynchronous reset, active low
//   flip           in   level flip request; its rising edge is the event
//   VGAid[31:0]    in   cell to flip, row*5+col, valid 0..24
//   x_topleft[9:0] in   board origin, pixel x
//   y_topleft[8:0] in   board origin, pixel y
//   pix_x[9:0]     in   current VGA pixel x
//   pix_y[8:0]     in   current VGA pixel y
//   in_board       out  pixel lies on the board
//   pix_cell[4:0]  out  cell under the pixel (0 when off the board)
//   pix_revealed   out  cell under the pixel is revealed
//   pix_mine       out  cell under the pixel holds a mine
//   pix_count[3:0] out  neighbour-mine count of the cell under the pixel
//   game_over      out  a mine has been flipped
//   game_won       out  every non-mine cell is revealed
//   busy           out  cascade in progress
//   revealed_count[4:0] out  number of revealed cells
module minesweeper_board #(
  parameter int          CELL_SIZE = 32,
  parameter logic [24:0] MINE_MASK = 25'h0010102
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flip,
  input  logic [31:0] VGAid,
  input  logic [9:0]  x_topleft,
  input  logic [8:0]  y_topleft,
  input  logic [9:0]  pix_x,
  input  logic [8:0]  pix_y,
  output logic        in_board,
  output logic [4:0]  pix_cell,
  output logic        pix_revealed,
  output logic        pix_mine,
  output logic [3:0]  pix_count,
  output logic        game_over,
  output logic        game_won,
  output logic        busy,
  output logic [4:0]  revealed_count
);

  localparam int          SHIFT      = $clog2(CELL_SIZE);
  localparam logic [12:0] BOARD_W    = 13'(5 * CELL_SIZE);
  localparam logic [11:0] BOARD_H    = 12'(5 * CELL_SIZE);
  localparam logic [4:0]  SAFE_CELLS = 5'(25 - $countones(MINE_MASK));

  function automatic logic [4:0] pop25(input logic [24:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 25; i++) n = n + {4'b0, v[i]};
    return n;
  endfunction

  // In-grid neighbours of cell idx; no wrap-around at edges.
  function automatic logic [24:0] nbr_mask(input int idx);
    logic [24:0] m;
    int r;
    int c;
    m = '0;
    r = idx / 5;
    c = idx % 5;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 5 &&
            (c + dc) >= 0 && (c + dc) < 5)
          m[(r + dr) * 5 + (c + dc)] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic [3:0] cell_count(input int idx);
    return 4'(pop25(nbr_mask(idx) & MINE_MASK));
  endfunction

  logic [24:0] revealed_q, revealed_d;
  logic        over_q, over_d;
  logic        busy_q, busy_d;
  logic        won_q, won_d;
  logic        flip_q;
  logic [4:0]  rcount_q, rcount_d;
  logic [3:0]  count_q [25];

  logic [24:0] zero_c;
  logic [24:0] spread_c;
  logic [24:0] newly_c;
  logic        flip_evt_c;
  logic [4:0]  sel_c;

  // Non-mine cells with no neighbouring mines seed the flood fill.
  always_comb begin
    zero_c = '0;
    for (int i = 0; i < 25; i++)
      zero_c[i] = (count_q[i] == 4'd0) && !MINE_MASK[i];
  end

  // One sweep: everything next to a revealed zero cell that is still hidden.
  always_comb begin
    spread_c = '0;
    for (int i = 0; i < 25; i++)
      if (revealed_q[i] && zero_c[i]) spread_c = spread_c | nbr_mask(i);
    newly_c = spread_c & ~revealed_q & ~MINE_MASK;
  end

  always_comb begin
    revealed_d = revealed_q;
    over_d     = over_q;
    busy_d     = busy_q;
    flip_evt_c = flip && !flip_q;
    sel_c      = VGAid[4:0];
    if (busy_q) begin
      // A flip edge arriving here is dropped, not queued.
      if (newly_c == '0) busy_d = 1'b0;
      else               revealed_d = revealed_q | newly_c;
    end else if (flip_evt_c && (VGAid <= 32'd24) && !over_q && !won_q) begin
      if (!revealed_q[sel_c]) begin
        if (MINE_MASK[sel_c]) begin
          revealed_d = revealed_q | MINE_MASK;
          over_d     = 1'b1;
        end else begin
          revealed_d[sel_c] = 1'b1;
          if (zero_c[sel_c]) busy_d = 1'b1;
        end
      end
    end
    rcount_d = pop25(revealed_q);
    won_d    = (rcount_q == SAFE_CELLS) && !over_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      revealed_q <= '0;
      over_q     <= 1'b0;
      busy_q     <= 1'b0;
      won_q      <= 1'b0;
      flip_q     <= 1'b0;
      rcount_q   <= '0;
      for (int i = 0; i < 25; i++) count_q[i] <= cell_count(i);
    end else begin
      revealed_q <= revealed_d;
      over_q     <= over_d;
      busy_q     <= busy_d;
      won_q      <= won_d;
      flip_q     <= flip;
      rcount_q   <= rcount_d;
    end
  end

  assign game_over      = over_q;
  assign game_won       = won_q;
  assign busy           = busy_q;
  assign revealed_count = rcount_q;

  // Pixel lookup: comparisons are 3 bits wider than the inputs so the
  // origin plus board size never wraps.
  logic [12:0] px_c, x0_c, dx_c;
  logic [11:0] py_c, y0_c, dy_c;
  logic [2:0]  col_c, row_c;
  logic [4:0]  cell_c;
  logic        in_c;
  logic        unused_c;

  always_comb begin
    px_c   = {3'b000, pix_x};
    x0_c   = {3'b000, x_topleft};
    py_c   = {3'b000, pix_y};
    y0_c   = {3'b000, y_topleft};
    dx_c   = px_c - x0_c;
    dy_c   = py_c - y0_c;
    in_c   = (px_c >= x0_c) && (px_c < x0_c + BOARD_W) &&
             (py_c >= y0_c) && (py_c < y0_c + BOARD_H);
    col_c  = dx_c[SHIFT +: 3];
    row_c  = dy_c[SHIFT +: 3];
    cell_c = {2'b00, row_c} * 5'd5 + {2'b00, col_c};

    in_board     = in_c;
    pix_cell     = '0;
    pix_revealed = 1'b0;
    pix_mine     = 1'b0;
    pix_count    = '0;
    if (in_c) begin
      pix_cell     = cell_c;
      pix_revealed = revealed_q[cell_c];
      pix_mine     = MINE_MASK[cell_c];
      pix_count    = count_q[cell_c];
    end
  end

  assign unused_c = ^{dx_c, dy_c};

endmodule

// File: tb/tb_minesweeper_board.sv
module tb_minesweeper_board;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flip = 1'b0;
  logic [31:0] VGAid = '0;
  logic [9:0]  x_topleft = '0;
  logic [8:0]  y_topleft = '0;
  logic [9:0]  pix_x = '0;
  logic [8:0]  pix_y = '0;
  logic        in_board;
  logic [4:0]  pix_cell;
  logic        pix_revealed;
  logic        pix_mine;
  logic [3:0]  pix_count;
  logic        game_over;
  logic        game_won;
  logic        busy;
  logic [4:0]  revealed_count;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int e;
  logic busy_seen;

  minesweeper_board dut (
    .clock(clock), .reset(reset), .flip(flip), .VGAid(VGAid),
    .x_topleft(x_topleft), .y_topleft(y_topleft),
    .pix_x(pix_x), .pix_y(pix_y),
    .in_board(in_board), .pix_cell(pix_cell), .pix_revealed(pix_revealed),
    .pix_mine(pix_mine), .pix_count(pix_count),
    .game_over(game_over), .game_won(game_won), .busy(busy),
    .revealed_count(revealed_count)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clock);
    flip  = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic do_flip(input logic [31:0] id, input int hold);
    @(negedge clock);
    VGAid = id;
    flip  = 1'b1;
    repeat (hold) begin
      @(negedge clock);
      if (busy) busy_seen = 1'b1;
    end
    flip = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (busy) busy_seen = 1'b1;
    end
  endtask

  // Point the pixel lookup at the centre of a cell with the origin at 0,0.
  task automatic probe(input int idx, output logic rev, output logic [3:0] cnt,
                       output logic mine);
    x_topleft = '0;
    y_topleft = '0;
    pix_x = 10'((idx % 5) * 32 + 16);
    pix_y = 9'((idx / 5) * 32 + 16);
    #1;
    rev  = pix_revealed;
    cnt  = pix_count;
    mine = pix_mine;
  endtask

  task automatic test_reset();
    int ids[5];
    int cnts[5];
    logic r, m;
    logic [3:0] c;
    ids  = '{2, 9, 20, 24, 12};
    cnts = '{2, 1, 1, 0, 2};
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    repeat (2) @(negedge clock);
    e = exp_q.pop_front(); checks++;
    if (int'(revealed_count) !== e) begin failures++; $display("FAIL reset_rcount got=%0d exp=%0d", revealed_count, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(game_over) !== e) begin failures++; $display("FAIL reset_over got=%0d exp=%0d", game_over, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(busy) !== e) begin failures++; $display("FAIL reset_busy got=%0d exp=%0d", busy, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(game_won) !== e) begin failures++; $display("FAIL reset_won got=%0d exp=%0d", game_won, e); end
    for (int k = 0; k < 5; k++) exp_q.push_back(cnts[k]);
    for (int k = 0; k < 5; k++) begin
      probe(ids[k], r, c, m);
      e = exp_q.pop_front(); checks++;
      if (int'(c) !== e) begin failures++; $display("FAIL reset_count[%0d] got=%0d exp=%0d", ids[k], c, e); end
    end
  endtask

  task automatic test_simple_flips();
    logic r, m;
    logic [3:0] c;
    busy_seen = 1'b0;
    do_flip(32'd9, 10);
    do_flip(32'd2, 10);
    do_flip(32'd20, 10);
    for (int i = 0; i < 25; i++) exp_q.push_back((i == 9 || i == 2 || i == 20) ? 1 : 0);
    for (int i = 0; i < 25; i++) begin
      probe(i, r, c, m);
      e = exp_q.pop_front(); checks++;
      if (int'(r) !== e) begin failures++; $display("FAIL simple_revealed[%0d] got=%0d exp=%0d", i, r, e); end
    end
    exp_q.push_back(3); exp_q.push_back(0);
    e = exp_q.pop_front(); checks++;
    if (int'(revealed_count) !== e) begin failures++; $display("FAIL simple_rcount got=%0d exp=%0d", revealed_count, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(busy_seen) !== e) begin failures++; $display("FAIL simple_busy_seen got=%0d exp=%0d", busy_seen, e); end
  endtask

  task automatic test_mine_lockout();
    logic r, m;
    logic [3:0] c;
    @(negedge clock);
    exp_q.push_back(0);
    e = exp_q.pop_front(); checks++;
    if (int'(game_over) !== e) begin failures++; $display("FAIL mine_over_before got=%0d exp=%0d", game_over, e); end
    VGAid = 32'd1;
    flip  = 1'b1;
    exp_q.push_back(1);
    @(negedge clock);
    e = exp_q.pop_front(); checks++;
    if (int'(game_over) !== e) begin failures++; $display("FAIL mine_over_next got=%0d exp=%0d", game_over, e); end
    repeat (9) @(negedge clock);
    flip = 1'b0;
    repeat (5) @(negedge clock);
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
    probe(1, r, c, m);
    e = exp_q.pop_front(); checks++;
    if (int'(r) !== e) begin failures++; $display("FAIL mine_rev1 got=%0d exp=%0d", r, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(m) !== e) begin failures++; $display("FAIL mine_pix_mine1 got=%0d exp=%0d", m, e); end
    probe(8, r, c, m);
    e = exp_q.pop_front(); checks++;
    if (int'(r) !== e) begin failures++; $display("FAIL mine_rev8 got=%0d exp=%0d", r, e); end
    probe(16, r, c, m);
    e = exp_q.pop_front(); checks++;
    if (int'(r) !== e) begin failures++; $display("FAIL mine_rev16 got=%0d exp=%0d", r, e); end
    exp_q.push_back(6);
    e = exp_q.pop_front(); checks++;
    if (int'(revealed_count) !== e) begin failures++; $display("FAIL mine_rcount got=%0d exp=%0d", revealed_count, e); end
    do_flip(32'd15, 10);
    exp_q.push_back(0); exp_q.push_back(6); exp_q.push_back(1);
    probe(15, r, c, m);
    e = exp_q.pop_front(); checks++;
    if (int'(r) !== e) begin failures++; $display("FAIL lockout_rev15 got=%0d exp=%0d", r, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(revealed_count) !== e) begin failures++; $display("FAIL lockout_rcount got=%0d exp=%0d", revealed_count, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(game_over) !== e) begin failures++; $display("FAIL lockout_over got=%0d exp=%0d", game_over, e); end
  endtask

  task automatic test_cascade();
    int busy_cycles;
    logic r, m;
    logic [3:0] c;
    apply_reset();
    busy_cycles = 0;
    @(negedge clock);
    VGAid = 32'd24;
    flip  = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clock);
      if (t == 5) flip = 1'b0;
      if (busy) busy_cycles++;
    end
    exp_q.push_back(3);
    e = exp_q.pop_front(); checks++;
    if (busy_cycles !== e) begin failures++; $display("FAIL cascade_busy_cycles got=%0d exp=%0d", busy_cycles, e); end
    for (int i = 0; i < 25; i++)
      exp_q.push_back((i == 12 || i == 13 || i == 14 || i == 17 || i == 18 ||
                       i == 19 || i == 22 || i == 23 || i == 24) ? 1 : 0);
    for (int i = 0; i < 25; i++) begin
      probe(i, r, c, m);
      e = exp_q.pop_front(); checks++;
      if (int'(r) !== e) begin failures++; $display("FAIL cascade_revealed[%0d] got=%0d exp=%0d", i, r, e); end
    end
    exp_q.push_back(9);
    e = exp_q.pop_front(); checks++;
    if (int'(revealed_count) !== e) begin failures++; $display("FAIL cascade_rcount got=%0d exp=%0d", revealed_count, e); end
  endtask

  // Runs on the state left by test_cascade (9 cells revealed).
  task automatic test_edge_cases();
    logic r, m;
    logic [3:0] c;
    busy_seen = 1'b0;
    do_flip(32'd30, 10);
    do_flip(32'h0100_0005, 10);
    exp_q.push_back(9); exp_q.push_back(0);
    e = exp_q.pop_front(); checks++;
    if (int'(revealed_count) !== e) begin failures++; $display("FAIL invalid_rcount got=%0d exp=%0d", revealed_count, e); end
    probe(5, r, c, m);
    e = exp_q.pop_front(); checks++;
    if (int'(r) !== e) begin failures++; $display("FAIL invalid_rev5 got=%0d exp=%0d", r, e); end
    do_flip(32'd24, 10);
    exp_q.push_back(9); exp_q.push_back(0);
    e = exp_q.pop_front(); checks++;
    if (int'(revealed_count) !== e) begin failures++; $display("FAIL reflip_rcount got=%0d exp=%0d", revealed_count, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(busy_seen) !== e) begin failures++; $display("FAIL reflip_busy got=%0d exp=%0d", busy_seen, e); end
    // Held flip: change the target mid-hold; a second event would reveal 3.
    @(negedge clock);
    VGAid = 32'd4;
    flip  = 1'b1;
    repeat (5) @(negedge clock);
    VGAid = 32'd3;
    repeat (95) @(negedge clock);
    flip = 1'b0;
    repeat (5) @(negedge clock);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(10);
    probe(4, r, c, m);
    e = exp_q.pop_front(); checks++;
    if (int'(r) !== e) begin failures++; $display("FAIL held_rev4 got=%0d exp=%0d", r, e); end
    probe(3, r, c, m);
    e = exp_q.pop_front(); checks++;
    if (int'(r) !== e) begin failures++; $display("FAIL held_rev3 got=%0d exp=%0d", r, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(revealed_count) !== e) begin failures++; $display("FAIL held_rcount got=%0d exp=%0d", revealed_count, e); end
  endtask

  task automatic test_pixel();
    apply_reset();
    do_flip(32'd7, 10);
    x_topleft = 10'd5;
    y_topleft = 9'd3;
    pix_x = 10'(5 + 32 * 2 + 1);
    pix_y = 9'(3 + 32 * 1);
    exp_q.push_back(1); exp_q.push_back(7); exp_q.push_back(1);
    exp_q.push_back(2); exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (int'(in_board) !== e) begin failures++; $display("FAIL pix_in_board got=%0d exp=%0d", in_board, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(pix_cell) !== e) begin failures++; $display("FAIL pix_cell got=%0d exp=%0d", pix_cell, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(pix_revealed) !== e) begin failures++; $display("FAIL pix_revealed got=%0d exp=%0d", pix_revealed, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(pix_count) !== e) begin failures++; $display("FAIL pix_count got=%0d exp=%0d", pix_count, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(pix_mine) !== e) begin failures++; $display("FAIL pix_mine got=%0d exp=%0d", pix_mine, e); end
    pix_x = 10'd4;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (int'(in_board) !== e) begin failures++; $display("FAIL pix_left_in_board got=%0d exp=%0d", in_board, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(pix_cell) !== e) begin failures++; $display("FAIL pix_left_cell got=%0d exp=%0d", pix_cell, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(pix_count) !== e) begin failures++; $display("FAIL pix_left_count got=%0d exp=%0d", pix_count, e); end
    pix_x = 10'd164;
    exp_q.push_back(1); exp_q.push_back(9);
    #1;
    e = exp_q.pop_front(); checks++;
    if (int'(in_board) !== e) begin failures++; $display("FAIL pix_right_in got=%0d exp=%0d", in_board, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(pix_cell) !== e) begin failures++; $display("FAIL pix_right_cell got=%0d exp=%0d", pix_cell, e); end
    pix_x = 10'd165;
    exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (int'(in_board) !== e) begin failures++; $display("FAIL pix_right_out got=%0d exp=%0d", in_board, e); end
    pix_x = 10'd70;
    pix_y = 9'd163;
    exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (int'(in_board) !== e) begin failures++; $display("FAIL pix_bottom_out got=%0d exp=%0d", in_board, e); end
  endtask

  task automatic test_win();
    apply_reset();
    for (int i = 0; i < 25; i++)
      if (i != 1 && i != 8 && i != 16) do_flip(32'(i), 4);
    repeat (3) @(negedge clock);
    exp_q.push_back(22); exp_q.push_back(1); exp_q.push_back(0);
    e = exp_q.pop_front(); checks++;
    if (int'(revealed_count) !== e) begin failures++; $display("FAIL win_rcount got=%0d exp=%0d", revealed_count, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(game_won) !== e) begin failures++; $display("FAIL win_won got=%0d exp=%0d", game_won, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(game_over) !== e) begin failures++; $display("FAIL win_over got=%0d exp=%0d", game_over, e); end
    do_flip(32'd1, 4);
    exp_q.push_back(0); exp_q.push_back(22);
    e = exp_q.pop_front(); checks++;
    if (int'(game_over) !== e) begin failures++; $display("FAIL won_lock_over got=%0d exp=%0d", game_over, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(revealed_count) !== e) begin failures++; $display("FAIL won_lock_rcount got=%0d exp=%0d", revealed_count, e); end
  endtask

  initial begin
    test_reset();
    test_simple_flips();
    test_mine_lockout();
    test_cascade();
    test_edge_cases();
    test_pixel();
    test_win();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
